bcd_scan_converter: RTL and testbench

Parametrised binary-to-BCD converter with a built-in multiplexed digit scanner, for driving multi-digit 7-segment displays.
- Accepts a WIDTH-bit unsigned value over a valid/ready handshake.
- Converts it sequentially (shift-and-add-3, one bit per clock) into DIGITS BCD digits held in a display register.
- Scans the digits out one at a time, with optional leading-zero blanking.
- Sits between the value source and the segment encoder / digit-enable driver.

---
 rtl/bcd_scan_converter.sv | 137 +++++++++++++
 tb/tb_bcd_scan_converter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding
// a free-running digit scanner with optional leading-zero blanking.
module bcd_scan_converter #(
    parameter int WIDTH            = 8,
    parameter int DIGITS           = 3,
    parameter int CYCLES_PER_DIGIT = 10,
    parameter int BLANK_LEADING    = 1
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic [WIDTH-1:0]                              in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [4*DIGITS-1:0]                           bcd_out,
    output logic                                          bcd_valid,
    output logic [3:0]                                    digit,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_place,
    output logic                                          digit_blank
);

    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    // ceil(WIDTH * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    localparam logic [PW-1:0] LAST_PLACE = PW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES_PER_DIGIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || CYCLES_PER_DIGIT < 1 || DIGITS < MIN_DIGITS) begin : g_bad_params
            $error("bcd_scan_converter: illegal parameters (DIGITS too small for WIDTH?)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     shift_reg;
    logic [4*DIGITS-1:0]  bcd_work, bcd_adj, bcd_next;
    logic [BW-1:0]        bit_cnt;
    logic [CW-1:0]        scan_cnt, scan_cnt_n;
    logic [PW-1:0]        place_n;
    logic [3:0]           digit_n;
    logic                 blank_n;

    assign in_ready = reset_n && (state == IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    // The display register only changes on a commit, so the scanner can see it one cycle early.
    assign bcd_next = (state == COMMIT) ? bcd_work : bcd_out;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bcd_work  <= '0;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= (state == COMMIT);
            bcd_out   <= bcd_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        bcd_work  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    bcd_work  <= {bcd_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (scan_cnt == LAST_COUNT) begin
            scan_cnt_n = '0;
            place_n    = (digit_place == '0) ? LAST_PLACE : digit_place - 1'b1;
        end else begin
            scan_cnt_n = scan_cnt + 1'b1;
            place_n    = digit_place;
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        digit_n = 4'd0;
        blank_n = (BLANK_LEADING != 0) && (place_n != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (PW'(i) == place_n) digit_n = bcd_next[4*i +: 4];
            if (PW'(i) >= place_n && bcd_next[4*i +: 4] != 4'd0) blank_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scan_cnt    <= '0;
            digit_place <= LAST_PLACE;
            digit       <= 4'd0;
            digit_blank <= (BLANK_LEADING != 0) && (DIGITS > 1);
        end else begin
            scan_cnt    <= scan_cnt_n;
            digit_place <= place_n;
            digit       <= digit_n;
            digit_blank <= blank_n;
        end
    end

endmodule

// File: tb/tb_bcd_scan_converter.sv
// Self-checking bench: three converter configurations checked every cycle against
// an arithmetic model of conversion latency, display contents and scan position.
module tb_bcd_scan_converter;

    localparam int NI = 3;
    localparam int WP[NI]  = '{8, 16, 8};
    localparam int DP[NI]  = '{3, 5, 3};
    localparam int CP[NI]  = '{10, 1, 3};
    localparam int BLP[NI] = '{1, 1, 0};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] dat[NI];
    logic        vld[NI];

    logic        a_ready, a_valid, a_blank, b_ready, b_valid, b_blank, c_ready, c_valid, c_blank;
    logic [11:0] a_bcd, c_bcd;
    logic [19:0] b_bcd;
    logic [3:0]  a_digit, b_digit, c_digit;
    logic [1:0]  a_place, c_place;
    logic [2:0]  b_place;

    logic        gotReady[NI], gotValid[NI], gotBlank[NI];
    logic [19:0] gotBcd[NI];
    logic [3:0]  gotDigit[NI];
    logic [2:0]  gotPlace[NI];

    int          checkCount = 0;
    int          passCount  = 0;
    string       nm[NI] = '{"A", "B", "C"};

    int          rem[NI];
    longint      lat[NI], val[NI];
    bit          vexp[NI];
    int          accCnt[NI];
    int          cyc = 0;
    bit          checkEn = 0;

    always #5 clock = ~clock;

    bcd_scan_converter #(.WIDTH(8), .DIGITS(3), .CYCLES_PER_DIGIT(10), .BLANK_LEADING(1)) u_a (
        .clock(clock), .reset_n(reset_n), .in_data(dat[0][7:0]), .in_valid(vld[0]),
        .in_ready(a_ready), .bcd_out(a_bcd), .bcd_valid(a_valid), .digit(a_digit),
        .digit_place(a_place), .digit_blank(a_blank));

    bcd_scan_converter #(.WIDTH(16), .DIGITS(5), .CYCLES_PER_DIGIT(1), .BLANK_LEADING(1)) u_b (
        .clock(clock), .reset_n(reset_n), .in_data(dat[1]), .in_valid(vld[1]),
        .in_ready(b_ready), .bcd_out(b_bcd), .bcd_valid(b_valid), .digit(b_digit),
        .digit_place(b_place), .digit_blank(b_blank));

    bcd_scan_converter #(.WIDTH(8), .DIGITS(3), .CYCLES_PER_DIGIT(3), .BLANK_LEADING(0)) u_c (
        .clock(clock), .reset_n(reset_n), .in_data(dat[2][7:0]), .in_valid(vld[2]),
        .in_ready(c_ready), .bcd_out(c_bcd), .bcd_valid(c_valid), .digit(c_digit),
        .digit_place(c_place), .digit_blank(c_blank));

    assign gotReady = '{a_ready, b_ready, c_ready};
    assign gotValid = '{a_valid, b_valid, c_valid};
    assign gotBlank = '{a_blank, b_blank, c_blank};
    assign gotBcd   = '{{8'd0, a_bcd}, b_bcd, {8'd0, c_bcd}};
    assign gotDigit = '{a_digit, b_digit, c_digit};
    assign gotPlace = '{{1'b0, a_place}, b_place, {1'b0, c_place}};

    function automatic longint pow10(input int n);
        longint p = 1;
        repeat (n) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] toBcd(input longint v, input int d);
        logic [63:0] r = '0;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: acceptance, WIDTH+1 edges to commit, scan position from cycles since reset.
    always @(posedge clock) begin
        if (!reset_n) begin
            checkEn = 1;
            cyc = 0;
        end else begin
            cyc++;
        end
        for (int i = 0; i < NI; i++) begin
            vexp[i] = 0;
            if (!reset_n) begin
                rem[i] = 0;
                val[i] = 0;
            end else if (rem[i] == 0) begin
                if (vld[i]) begin
                    lat[i] = longint'(dat[i]) & (pow10(0) * ((longint'(1) << WP[i]) - 1));
                    rem[i] = WP[i] + 1;
                    accCnt[i]++;
                end
            end else begin
                rem[i]--;
                if (rem[i] == 0) begin
                    val[i]  = lat[i];
                    vexp[i] = 1;
                end
            end
        end
        #1;
        if (checkEn) begin
            for (int i = 0; i < NI; i++) begin
                int     pl;
                longint hi;
                pl = DP[i] - 1 - ((cyc / CP[i]) % DP[i]);
                hi = val[i] / pow10(pl);
                checkOutput($sformatf("%s.in_ready", nm[i]), 64'(gotReady[i]), 64'(reset_n && rem[i] == 0));
                checkOutput($sformatf("%s.bcd_valid", nm[i]), 64'(gotValid[i]), 64'(vexp[i]));
                checkOutput($sformatf("%s.bcd_out", nm[i]), 64'(gotBcd[i]), toBcd(val[i], DP[i]));
                checkOutput($sformatf("%s.digit_place", nm[i]), 64'(gotPlace[i]), 64'(pl));
                checkOutput($sformatf("%s.digit", nm[i]), 64'(gotDigit[i]), 64'(hi % 10));
                checkOutput($sformatf("%s.digit_blank", nm[i]), 64'(gotBlank[i]),
                            64'(BLP[i] != 0 && pl > 0 && hi == 0));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) if (!vld[i]) dat[i] = 16'($urandom);
        end
    endtask

    task automatic applyStimulus(input int i, input longint v, input bit hold);
        int start;
        int n;
        @(negedge clock);
        dat[i] = v[15:0];
        vld[i] = 1'b1;
        start  = accCnt[i];
        n      = 0;
        while (accCnt[i] == start && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (accCnt[i] == start) checkOutput($sformatf("%s.accept_timeout", nm[i]), 64'(accCnt[i]), 64'(start + 1));
        if (!hold) begin
            vld[i] = 1'b0;
            dat[i] = 16'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            dat[i] = '0;
            vld[i] = 1'b0;
            rem[i] = 0;
            lat[i] = 0;
            val[i] = 0;
            accCnt[i] = 0;
        end
        $display("[TB] start");
        idle(3);
        reset_n = 1'b1;
        idle(5);

        applyStimulus(0, 255, 0);  idle(40);
        applyStimulus(0, 205, 0);  idle(40);
        applyStimulus(0, 7, 0);    idle(40);
        applyStimulus(0, 0, 0);    idle(40);

        applyStimulus(0, 99, 1);
        applyStimulus(0, 100, 0);  idle(40);

        applyStimulus(0, 200, 0);
        idle(4);
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        idle(5);
        applyStimulus(0, 13, 0);   idle(40);

        applyStimulus(1, 65535, 0); idle(25);
        applyStimulus(1, 10000, 0); idle(25);
        applyStimulus(1, 0, 0);     idle(25);

        applyStimulus(2, 7, 0);    idle(15);
        applyStimulus(2, 0, 0);    idle(15);
        applyStimulus(2, 205, 0);  idle(15);

        repeat (12) begin
            for (int i = 0; i < NI; i++) begin
                longint v;
                v = longint'($urandom) & ((longint'(1) << WP[i]) - 1);
                applyStimulus(i, v, 0);
                idle($urandom_range(0, 35));
            end
        end
        idle(40);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
